// File: rtl/sys_array_pkg.sv
// rtl/sys_array_pkg.sv - shared state type and sizing helpers for the systolic matrix-vector engine
package sys_array_pkg;

  typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_DRAIN} state_e;

  function automatic int acc_width(input int data_width, input int array_l);
    return 2 * data_width + $clog2(array_l);
  endfunction

  // Input register + ARRAY_L-1 skew hops + ARRAY_W PE rows + deskew + output register.
  function automatic int calc_lat(input int array_w, input int array_l);
    return array_l + array_w;
  endfunction

endpackage

// File: rtl/sys_array_stream_if.sv
// rtl/sys_array_stream_if.sv - weight, input-vector and result ports of the systolic engine
interface sys_array_stream_if
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W    = 4,
  parameter int ARRAY_L    = 4,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, ARRAY_L)
);
  logic                               weight_valid;
  logic                               weight_ready;
  logic [ARRAY_L-1:0][DATA_WIDTH-1:0] weight_row;
  logic [$clog2(ARRAY_L+1)-1:0]       cfg_len;
  logic                               in_valid;
  logic                               in_ready;
  logic [ARRAY_L-1:0][DATA_WIDTH-1:0] in_data;
  logic                               out_valid;
  logic [ARRAY_W-1:0][ACC_WIDTH-1:0]  out_data;
  logic                               busy;

  modport master (
    output weight_valid, weight_row, cfg_len, in_valid, in_data,
    input  weight_ready, in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  weight_valid, weight_row, cfg_len, in_valid, in_data,
    output weight_ready, in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/sys_array_pe.sv
// rtl/sys_array_pe.sv - one weight-stationary PE: registered MAC, x passed down, valid passed right
module sys_array_pe #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 18
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         w_we,
  input  logic signed [DATA_WIDTH-1:0] w_in,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  input  logic                         v_in,
  input  logic signed [ACC_WIDTH-1:0]  ps_in,
  output logic signed [DATA_WIDTH-1:0] x_out,
  output logic                         v_out,
  output logic signed [ACC_WIDTH-1:0]  ps_out
);
  localparam int PW = 2 * DATA_WIDTH;

  logic signed [DATA_WIDTH-1:0] w_q, w_d, x_q, x_d;
  logic                         v_q, v_d;
  logic signed [ACC_WIDTH-1:0]  ps_q, ps_d;
  logic signed [PW-1:0]         prod;

  always_comb begin
    w_d  = w_we ? w_in : w_q;
    x_d  = x_in;
    v_d  = v_in;
    prod = PW'(w_q) * PW'(x_in);
    ps_d = ps_in + ACC_WIDTH'(prod);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q  <= '0;
      x_q  <= '0;
      v_q  <= 1'b0;
      ps_q <= '0;
    end else begin
      w_q  <= w_d;
      x_q  <= x_d;
      v_q  <= v_d;
      ps_q <= ps_d;
    end
  end

  assign x_out  = x_q;
  assign v_out  = v_q;
  assign ps_out = ps_q;
endmodule

// File: rtl/sys_array_stream.sv
// rtl/sys_array_stream.sv - skewed weight-stationary signed matrix-vector engine with load/run/drain control
module sys_array_stream
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W    = 4,
  parameter int ARRAY_L    = 4,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, ARRAY_L)
) (
  input logic               clk,
  input logic               reset,
  sys_array_stream_if.slave bus
);
  localparam int LAT   = calc_lat(ARRAY_W, ARRAY_L);
  localparam int LEN_W = $clog2(ARRAY_L + 1);
  localparam int K_W   = (ARRAY_W > 1) ? $clog2(ARRAY_W) : 1;
  localparam int CNT_W = $clog2(LAT + 1);

  state_e                             state_q, state_d;
  logic [K_W-1:0]                     k_q, k_d;
  logic [LEN_W-1:0]                   len_q, len_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [ARRAY_L-1:0][DATA_WIDTH-1:0] xin_q, xin_d;
  logic                               vin_q, vin_d;
  logic [ARRAY_W-1:0][ACC_WIDTH-1:0]  out_data_q, out_data_d;
  logic                               out_valid_q, out_valid_d;
  logic                               w_acc, in_acc;
  logic [ARRAY_W-1:0]                 row_we, row_v;
  logic [ACC_WIDTH-1:0]               row_ps  [ARRAY_W];
  logic [DATA_WIDTH-1:0]              col_x   [ARRAY_L];
  logic [DATA_WIDTH-1:0]              x_pipe  [ARRAY_W+1][ARRAY_L];
  logic [ACC_WIDTH-1:0]               ps_pipe [ARRAY_W][ARRAY_L+1];
  logic                               v_pipe  [ARRAY_W][ARRAY_L];

  assign bus.weight_ready = (state_q == ST_LOAD);
  assign bus.in_ready     = (state_q == ST_RUN);
  assign bus.busy         = (state_q != ST_RUN) || (cnt_q != '0);
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign w_acc            = (state_q == ST_LOAD) && bus.weight_valid;
  assign in_acc           = (state_q == ST_RUN) && bus.in_valid;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_LOAD: begin
        if (w_acc) begin
          if (k_q == K_W'(ARRAY_W - 1)) begin
            state_d = ST_RUN;
            k_d     = '0;
            len_d   = (bus.cfg_len > LEN_W'(ARRAY_L)) ? LEN_W'(ARRAY_L) : bus.cfg_len;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      ST_RUN:   if (bus.weight_valid) state_d = ST_DRAIN;
      ST_DRAIN: if (cnt_q == '0) state_d = ST_LOAD;
      default:  state_d = ST_LOAD;
    endcase
    // Countdown to the emergence of the youngest accepted vector.
    if (in_acc) cnt_d = CNT_W'(LAT);
    else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    for (int r = 0; r < ARRAY_W; r++) row_we[r] = w_acc && (k_q == K_W'(r));
    for (int c = 0; c < ARRAY_L; c++)
      xin_d[c] = (in_acc && (LEN_W'(c) < len_q)) ? bus.in_data[c] : '0;
    vin_d       = in_acc;
    out_valid_d = &row_v;
    out_data_d  = out_data_q;
    for (int r = 0; r < ARRAY_W; r++)
      if (out_valid_d) out_data_d[r] = row_ps[r];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      k_q         <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      xin_q       <= '0;
      vin_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      xin_q       <= xin_d;
      vin_q       <= vin_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  for (genvar c = 0; c < ARRAY_L; c++) begin : g_skew
    if (c == 0) begin : g_direct
      assign col_x[c] = xin_q[c];
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] sk_q [c];
      logic [DATA_WIDTH-1:0] sk_d [c];
      always_comb begin
        sk_d[0] = xin_q[c];
        for (int i = 1; i < c; i++) sk_d[i] = sk_q[i-1];
      end
      always_ff @(posedge clk) begin
        if (reset) sk_q <= '{default: '0};
        else       sk_q <= sk_d;
      end
      assign col_x[c] = sk_q[c-1];
    end
    assign x_pipe[0][c] = col_x[c];
  end

  // Valid enters at column 0 of each row and rides rightward with the partial sum.
  for (genvar r = 0; r < ARRAY_W; r++) begin : g_row
    assign ps_pipe[r][0] = '0;
    for (genvar c = 0; c < ARRAY_L; c++) begin : g_col
      logic v_left;
      if (c == 0) begin : g_v0
        if (r == 0) begin : g_first
          assign v_left = vin_q;
        end else begin : g_down
          assign v_left = v_pipe[r-1][0];
        end
      end else begin : g_vc
        assign v_left = v_pipe[r][c-1];
      end
      sys_array_pe #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_pe (
        .clk    (clk),
        .reset  (reset),
        .w_we   (row_we[r]),
        .w_in   (bus.weight_row[c]),
        .x_in   (x_pipe[r][c]),
        .v_in   (v_left),
        .ps_in  (ps_pipe[r][c]),
        .x_out  (x_pipe[r+1][c]),
        .v_out  (v_pipe[r][c]),
        .ps_out (ps_pipe[r][c+1])
      );
    end
  end

  for (genvar r = 0; r < ARRAY_W; r++) begin : g_deskew
    localparam int D = ARRAY_W - 1 - r;
    if (D == 0) begin : g_direct
      assign row_ps[r] = ps_pipe[r][ARRAY_L];
      assign row_v[r]  = v_pipe[r][ARRAY_L-1];
    end else begin : g_delay
      logic [ACC_WIDTH-1:0] dps_q [D];
      logic [ACC_WIDTH-1:0] dps_d [D];
      logic [D-1:0]         dv_q, dv_d;
      always_comb begin
        dps_d[0] = ps_pipe[r][ARRAY_L];
        dv_d     = '0;
        dv_d[0]  = v_pipe[r][ARRAY_L-1];
        for (int i = 1; i < D; i++) begin
          dps_d[i] = dps_q[i-1];
          dv_d[i]  = dv_q[i-1];
        end
      end
      always_ff @(posedge clk) begin
        if (reset) begin
          dps_q <= '{default: '0};
          dv_q  <= '0;
        end else begin
          dps_q <= dps_d;
          dv_q  <= dv_d;
        end
      end
      assign row_ps[r] = dps_q[D-1];
      assign row_v[r]  = dv_q[D-1];
    end
  end
endmodule

// File: tb/tb_sys_array_stream.sv
// tb/tb_sys_array_stream.sv - randomized scoreboard bench for sys_array_stream
`timescale 1ns/1ps
module tb_sys_array_stream;
  import sys_array_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int AL    = 4;
  localparam int ACC   = 2 * DW + 2;
  localparam int LAT   = AL + AW;
  localparam int LEN_W = 3;

  typedef struct packed {
    logic [AW-1:0][31:0] y;
    logic [31:0]         cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sys_array_stream_if #(.DATA_WIDTH(DW), .ARRAY_W(AW), .ARRAY_L(AL), .ACC_WIDTH(ACC)) bus ();

  sys_array_stream #(.DATA_WIDTH(DW), .ARRAY_W(AW), .ARRAY_L(AL), .ACC_WIDTH(ACC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t exp_q [$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   wm [AW][AL];
  int   len_m = 0;
  int   last_out_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("latency", cyc, int'(e.cyc));
        for (int r = 0; r < AW; r++)
          chk($sformatf("y[%0d]", r), int'($signed(bus.out_data[r])), int'(e.y[r]));
      end
    end
  end

  task automatic push_vec(input int xv [AL]);
    exp_t e;
    int   s;
    for (int r = 0; r < AW; r++) begin
      s = 0;
      for (int c = 0; c < len_m; c++) s += wm[r][c] * xv[c];
      e.y[r] = s;
    end
    e.cyc        = cyc + 1 + LAT;
    last_out_cyc = cyc + 1 + LAT;
    exp_q.push_back(e);
  endtask

  task automatic drive_x(input int xv [AL]);
    for (int c = 0; c < AL; c++) bus.in_data[c] = DW'(xv[c]);
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    bus.in_valid     = 1'b0;
    bus.weight_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    for (int r = 0; r < AW; r++)
      for (int c = 0; c < AL; c++) wm[r][c] = 0;
    len_m = 0;
    chk("rst_weight_ready", int'(bus.weight_ready), 1);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_busy", int'(bus.busy), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data_zero", int'(bus.out_data == '0), 1);
  endtask

  task automatic load_weights(input int w [AW][AL], input int cl);
    bus.cfg_len = LEN_W'(cl);
    for (int r = 0; r < AW; r++) begin
      bus.weight_valid = 1'b1;
      for (int c = 0; c < AL; c++) bus.weight_row[c] = DW'(w[r][c]);
      chk("weight_ready_load", int'(bus.weight_ready), 1);
      @(negedge clk);
    end
    bus.weight_valid = 1'b0;
    wm    = w;
    len_m = (cl > AL) ? AL : cl;
    chk("in_ready_after_load", int'(bus.in_ready), 1);
    chk("busy_idle_run", int'(bus.busy), 0);
  endtask

  task automatic send(input int xv [AL]);
    drive_x(xv);
    bus.in_valid = 1'b1;
    if (bus.in_ready === 1'b1) push_vec(xv);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input bit with_vec, input int xv [AL]);
    int n;
    int start;
    bus.weight_valid = 1'b1;
    if (with_vec) begin
      drive_x(xv);
      bus.in_valid = 1'b1;
      if (bus.in_ready === 1'b1) push_vec(xv);
    end
    start = cyc;
    @(negedge clk);
    bus.weight_valid = 1'b0;
    bus.in_valid     = 1'b0;
    chk("in_ready_in_drain", int'(bus.in_ready), 0);
    n = 0;
    while (bus.weight_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", int'(n < 40), 1);
    chk("wr_after_last_out", int'(cyc > last_out_cyc), 1);
    chk("wr_drain_prompt", int'(cyc <= ((last_out_cyc > start + 1) ? last_out_cyc : start + 1) + 2), 1);
  endtask

  int w [AW][AL];
  int xv [AL];
  int zero_x [AL];
  int n;

  initial begin
    bus.weight_valid = 1'b0;
    bus.in_valid     = 1'b0;
    bus.weight_row   = '0;
    bus.in_data      = '0;
    bus.cfg_len      = '0;
    zero_x           = '{0, 0, 0, 0};
    do_reset();

    for (int r = 0; r < AW; r++)
      for (int c = 0; c < AL; c++) w[r][c] = (r == c) ? 1 : 0;
    load_weights(w, 4);
    xv = '{1, 2, 3, 4};
    send(xv);
    chk("busy_inflight", int'(bus.busy), 1);
    drain(1'b0, zero_x);

    for (int r = 0; r < AW; r++)
      for (int c = 0; c < AL; c++) w[r][c] = -128;
    load_weights(w, 4);
    xv = '{-128, -128, -128, -128};
    send(xv);
    drain(1'b0, zero_x);

    for (int r = 0; r < AW; r++)
      for (int c = 0; c < AL; c++) w[r][c] = 1;
    xv = '{1, 2, 3, 4};
    load_weights(w, 2);
    send(xv);
    drain(1'b0, zero_x);
    load_weights(w, 0);
    send(xv);
    drain(1'b0, zero_x);
    load_weights(w, 7);
    send(xv);
    drain(1'b0, zero_x);

    for (int r = 0; r < AW; r++)
      for (int c = 0; c < AL; c++) w[r][c] = (c == 0) ? r + 1 : 0;
    load_weights(w, 4);
    for (int k = 1; k <= 6; k++) begin
      xv = '{k, 0, 0, 0};
      send(xv);
    end
    xv = '{7, 1, 1, 1};
    drain(1'b1, xv);

    load_weights(w, 4);
    xv = '{5, 5, 5, 5};
    send(xv);
    repeat (2) @(negedge clk);
    do_reset();
    repeat (12) @(negedge clk);
    for (int r = 0; r < AW; r++)
      for (int c = 0; c < AL; c++) w[r][c] = 0;
    load_weights(w, 4);
    send(xv);
    drain(1'b0, zero_x);

    for (int round = 0; round < 4; round++) begin
      for (int r = 0; r < AW; r++)
        for (int c = 0; c < AL; c++) w[r][c] = int'($urandom_range(255)) - 128;
      load_weights(w, int'($urandom_range(7)));
      for (int v = 0; v < 16; v++) begin
        for (int c = 0; c < AL; c++) xv[c] = int'($urandom_range(255)) - 128;
        if ($urandom_range(3) == 0) repeat (int'($urandom_range(2)) + 1) @(negedge clk);
        send(xv);
      end
      for (int c = 0; c < AL; c++) xv[c] = int'($urandom_range(255)) - 128;
      drain(1'($urandom_range(1)), xv);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
